// File: rtl/tlc_pkg.sv
// Shared types for the intersection phase scheduler.
//   - lamp codes GREEN/YELLOW/RED (2-bit, same for highway and country)
//   - phase_e : 3-bit phase code, also exported on the debug port
//   - tgt_e   : which request an HG exit is serving
//   - lamps_t / lamps_of : lamp pattern for each phase
package tlc_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [2:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    AR1  = 3'd2,
    CG   = 3'd3,
    CY   = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6
  } phase_e;

  typedef enum logic {
    CTRY = 1'b0,
    PED  = 1'b1
  } tgt_e;

  typedef struct packed {
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
  } lamps_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Unknown codes show the reset (HG) pattern.
  function automatic lamps_t lamps_of(input phase_e p);
    lamps_t l;
    l = '{hwy: RED, cntry: RED, walk: 1'b0};
    case (p)
      HG:      l.hwy   = GREEN;
      HY:      l.hwy   = YELLOW;
      CG:      l.cntry = GREEN;
      CY:      l.cntry = YELLOW;
      WALK:    l.walk  = 1'b1;
      AR1, AR2: ;
      default: l.hwy   = GREEN;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Slow-tick generator: one-clk-wide tick every CLK_DIV clks.
//   clk   in  : system clock
//   clr_n in  : async active-low reset
//   tick  out : registered pulse, high while the counter sits at CLK_DIV-1
module tlc_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it coincides with cnt==LAST.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/tlc_phase_sched.sv
// Intersection phase scheduler: tick prescaler, sensor synchronizer,
// pedestrian latch, country/ped arbitration and the lamp-phase FSM.
//   clk, clr_n        : clock, async active-low reset
//   x                 : country car sensor (async level)
//   ped_req           : pedestrian request pulse
//   slowclk           : slow tick pulse
//   hwy, cntry        : lamp codes (00 green, 01 yellow, 10 red)
//   ped_walk          : walk lamp
//   phase             : current phase code (debug)
module tlc_phase_sched
  import tlc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int T_HWY_MIN   = 3,
  parameter int T_CNTRY_MAX = 5,
  parameter int T_YEL       = 2,
  parameter int T_AR        = 1,
  parameter int T_WALK      = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       x,
  input  logic       ped_req,
  output logic       slowclk,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam int TMAX = imax(imax(imax(T_HWY_MIN, T_CNTRY_MAX), imax(T_YEL, T_AR)), T_WALK);
  localparam int PW   = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PT_HWY = PW'(T_HWY_MIN - 1);
  localparam logic [PW-1:0] PT_CGM = PW'(T_CNTRY_MAX - 1);
  localparam logic [PW-1:0] PT_YEL = PW'(T_YEL - 1);
  localparam logic [PW-1:0] PT_AR  = PW'(T_AR - 1);
  localparam logic [PW-1:0] PT_WLK = PW'(T_WALK - 1);

  logic          tick;
  phase_e        ph, nxt;
  tgt_e          tgt, tgt_n, last;
  logic [PW-1:0] pt;
  logic          x_m, x_s;
  logic          ped_pend;
  logic          entry;
  lamps_t        lamp_q;

  tlc_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick)
  );

  always_comb begin
    nxt   = ph;
    tgt_n = tgt;
    case (ph)
      HG: if (tick && pt >= PT_HWY && (x_s || ped_pend)) begin
        nxt = HY;
        // On contention serve whoever was not served last.
        if (x_s && ped_pend) tgt_n = (last == PED) ? CTRY : PED;
        else                 tgt_n = x_s ? CTRY : PED;
      end
      HY:   if (tick && pt == PT_YEL) nxt = AR1;
      AR1:  if (tick && pt == PT_AR)  nxt = (tgt == CTRY) ? CG : WALK;
      CG:   if (tick && (!x_s || pt == PT_CGM)) nxt = CY;
      CY:   if (tick && pt == PT_YEL) nxt = AR2;
      WALK: if (tick && pt == PT_WLK) nxt = AR2;
      AR2:  if (tick && pt == PT_AR)  nxt = HG;
      default: nxt = HG;   // illegal code recovers without waiting for a tick
    endcase
  end

  assign entry = (nxt != ph);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ph       <= HG;
      tgt      <= CTRY;
      last     <= PED;
      pt       <= '0;
      x_m      <= 1'b0;
      x_s      <= 1'b0;
      ped_pend <= 1'b0;
      lamp_q   <= lamps_of(HG);
    end else begin
      ph     <= nxt;
      tgt    <= tgt_n;
      x_m    <= x;
      x_s    <= x_m;
      lamp_q <= lamps_of(nxt);

      if (entry)                 pt <= '0;
      else if (tick && pt != '1) pt <= pt + PW'(1);

      // Clear wins over a request arriving on the WALK entry edge.
      if (entry && nxt == WALK) ped_pend <= 1'b0;
      else if (ped_req)         ped_pend <= 1'b1;

      if (entry && nxt == CG)        last <= CTRY;
      else if (entry && nxt == WALK) last <= PED;
    end
  end

  assign slowclk  = tick;
  assign hwy      = lamp_q.hwy;
  assign cntry    = lamp_q.cntry;
  assign ped_walk = lamp_q.walk;
  assign phase    = ph;

endmodule

// File: tb/tb_tlc_phase_sched.sv
module tb_tlc_phase_sched;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       x = 1'b0;
  logic       ped_req = 1'b0;
  logic       slowclk;
  logic [1:0] hwy, cntry;
  logic       ped_walk;
  logic [2:0] phase;

  tlc_phase_sched dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .x        (x),
    .ped_req  (ped_req),
    .slowclk  (slowclk),
    .hwy      (hwy),
    .cntry    (cntry),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Lamp pattern {hwy, cntry, walk} for each phase code.
  function automatic int exp_lamps(input int ph);
    case (ph)
      0: return {2'b00, 2'b10, 1'b0};
      1: return {2'b01, 2'b10, 1'b0};
      2: return {2'b10, 2'b10, 1'b0};
      3: return {2'b10, 2'b00, 1'b0};
      4: return {2'b10, 2'b01, 1'b0};
      5: return {2'b10, 2'b10, 1'b0};
      6: return {2'b10, 2'b10, 1'b1};
      default: return 0;
    endcase
  endfunction

  // ---------------- phase-segment scoreboard ----------------
  typedef struct { int ph; int clks; } seg_t;
  seg_t exp_q[$];

  bit         mon_en = 1'b0;
  int         cur_ph, cur_len;
  logic [4:0] cur_l;

  task automatic push(input int ph, input int ticks);
    seg_t s;
    s.ph = ph;
    s.clks = ticks * 4;
    exp_q.push_back(s);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(phase) != cur_ph) begin
        if (exp_q.size() == 0) begin
          chk("extra_segment", cur_ph, -1);
        end else begin
          seg_t e;
          e = exp_q.pop_front();
          chk("seg_phase", cur_ph, e.ph);
          chk("seg_clks", cur_len, e.clks);
          chk("seg_lamps", int'(cur_l), exp_lamps(e.ph));
        end
        cur_ph  = int'(phase);
        cur_len = 1;
        cur_l   = {hwy, cntry, ped_walk};
      end else begin
        cur_len++;
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    #1;
    cur_ph  = 0;
    cur_len = 1;        // release counts as the HG entry edge
    cur_l   = {hwy, cntry, ped_walk};
    mon_en  = 1'b1;
  endtask

  task automatic ped_pulse();
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int lim, input string nm);
    int n = 0;
    while (int'(phase) != ph && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(phase), ph);
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- reset / prescaler vector table ----------------
  typedef struct {
    logic       clr_n;
    logic       exp_slow;
    logic [1:0] exp_hwy;
    logic [1:0] exp_cntry;
    logic [2:0] exp_ph;
  } vec_t;
  vec_t vt[17];

  initial begin
    // 3 clks in reset, then 14 clks running with no requests. Vector i is
    // sampled on the falling edge after the i-th drive, so release vector j
    // (i=3+j) sees rising edge j+1; slowclk must be high heading into
    // rising edges 4, 8, 12.
    for (int i = 0; i < 17; i++) begin
      vt[i].clr_n     = (i >= 3);
      vt[i].exp_slow  = (i >= 3) && (((i - 3) % 4) == 2);
      vt[i].exp_hwy   = 2'b00;
      vt[i].exp_cntry = 2'b10;
      vt[i].exp_ph    = 3'd0;
    end

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      clr_n = vt[i].clr_n;
      x = 1'b0;
      ped_req = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_slowclk", i), int'(slowclk), int'(vt[i].exp_slow));
      chk($sformatf("vec%0d_hwy", i),     int'(hwy),     int'(vt[i].exp_hwy));
      chk($sformatf("vec%0d_cntry", i),   int'(cntry),   int'(vt[i].exp_cntry));
      chk($sformatf("vec%0d_phase", i),   int'(phase),   int'(vt[i].exp_ph));
      if (i < 3) chk($sformatf("vec%0d_walk", i), int'(ped_walk), 0);
    end

    // ---- max country green: x held high ----
    x = 1'b1;
    push(0, 3); push(1, 2); push(2, 1); push(3, 5); push(4, 2); push(5, 1);
    do_reset();
    wait_drain(400, "maxcg_drain");
    chk("maxcg_back_hg", int'(phase), 0);
    chk("maxcg_back_hwy", int'(hwy), 0);

    // ---- early country exit: x drops once CG is entered ----
    x = 1'b1;
    push(0, 3); push(1, 2); push(2, 1); push(3, 1); push(4, 2); push(5, 1);
    do_reset();
    wait_phase(3, 200, "early_reach_cg");
    x = 1'b0;
    wait_drain(200, "early_drain");

    // ---- pedestrian only ----
    x = 1'b0;
    push(0, 3); push(1, 2); push(2, 1); push(6, 2); push(5, 1);
    do_reset();
    ped_pulse();
    chk("ped_pend_set", int'(dut.ped_pend), 1);
    wait_phase(6, 200, "ped_reach_walk");
    chk("ped_pend_walk", int'(dut.ped_pend), 0);
    chk("ped_walk_lamp", int'(ped_walk), 1);
    wait_drain(200, "ped_drain");
    chk("ped_back_hg", int'(phase), 0);

    // ---- contention: country, then ped, then country ----
    x = 1'b1;
    push(0, 3); push(1, 2); push(2, 1); push(3, 5); push(4, 2); push(5, 1);
    push(0, 3); push(1, 2); push(2, 1); push(6, 2); push(5, 1);
    push(0, 3); push(1, 2); push(2, 1); push(3, 5);
    do_reset();
    ped_pulse();
    wait_drain(800, "cont_drain");

    // ---- reset in the middle of CG ----
    x = 1'b1;
    push(0, 3); push(1, 2); push(2, 1);
    do_reset();
    wait_phase(3, 200, "mid_reach_cg");
    repeat (8) @(negedge clk);
    chk("mid_pt", int'(dut.pt), 2);
    chk("mid_still_cg", int'(phase), 3);
    chk("mid_q_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    chk("mid_rst_hwy", int'(hwy), 0);
    chk("mid_rst_cntry", int'(cntry), 2);
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_walk", int'(ped_walk), 0);
    chk("mid_rst_slow", int'(slowclk), 0);
    push(0, 3); push(1, 2);
    do_reset();
    wait_drain(200, "mid_restart_drain");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/tlc_phase_sched.md
# tlc_phase_sched

Phase scheduler for the highway/country intersection controller. Generates the slow timing tick from the system clock, arbitrates between the country-road car sensor and a pedestrian push-button, and sequences the light phases with tick-counted durations. Drives the 2-bit highway and country lamp codes and the walk lamp directly. It is the timing and arbitration core the intersection top level instantiates.

## Interface
- `CLK_DIV`, default 4: clk cycles per slow tick (≥2).
- `T_HWY_MIN`, default 3: minimum highway-green duration in ticks (≥1).
- `T_CNTRY_MAX`, default 5: maximum country-green duration in ticks (≥1).
- `T_YEL`, default 2: yellow duration in ticks (≥1).
- `T_AR`, default 1: all-red clearance duration in ticks (≥1).
- `T_WALK`, default 2: pedestrian walk duration in ticks (≥1).

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `clr_n`  in  1: asynchronous, active-low reset.
- `x`  in  1: country-road car sensor, level, asynchronous to clk.
- `ped_req`  in  1: pedestrian request; any clk-wide high pulse counts.
- `slowclk`  out  1: one-clk-wide tick pulse, every `CLK_DIV` clks.
- `hwy`  out  2: highway lamp code: 00 green, 01 yellow, 10 red.
- `cntry`  out  2: country lamp code, same encoding.
- `ped_walk`  out  1: walk lamp.
- `phase`  out  3: current state, for debug.

## Operation
- Prescaler: counter 0..CLK_DIV-1. `slowclk`=1 on the cycle the counter equals CLK_DIV-1, then the counter wraps to 0.
- `x` passes through a 2-flop synchronizer to give `x_s`. `ped_req` sets `ped_pend` on any clk edge. `ped_pend` clears on the clk edge that enters WALK. A set and a clear on the same edge resolve to clear.
- Phase timer `pt`: cleared on every state entry. Increments on each tick and saturates at its maximum value.
- Phase encodings:
  - HG = 0: hwy=00, cntry=10.
  - HY = 1: hwy=01, cntry=10.
  - AR1 = 2: hwy=10, cntry=10.
  - CG = 3: hwy=10, cntry=00.
  - CY = 4: hwy=10, cntry=01.
  - AR2 = 5: hwy=10, cntry=10.
  - WALK = 6: hwy=10, cntry=10, ped_walk=1.
- Transitions, evaluated only on tick cycles:
  - HG→HY when pt ≥ T_HWY_MIN-1 and (x_s or ped_pend). At this point the target `tgt` (CTRY or PED) is latched.
  - HY→AR1 at pt = T_YEL-1.
  - AR1→CG if tgt=CTRY, else AR1→WALK, at pt = T_AR-1.
  - CG→CY when !x_s or pt = T_CNTRY_MAX-1.
  - CY→AR2 at pt = T_YEL-1.
  - WALK→AR2 at pt = T_WALK-1.
  - AR2→HG at pt = T_AR-1.
- Arbitration at HG exit:
  - Only x_s pending: CTRY.
  - Only ped_pend: PED.
  - Both pending: the opposite of `last` (last served). `last` resets to PED, so country wins the first contest.
  - `last` updates on entry to CG or WALK.
- Illegal `phase` codes (7) go to HG on the next clk.

## Timing
- Reset (clr_n low, asynchronous):
  - phase=HG, hwy=00, cntry=10, ped_walk=0, slowclk=0.
  - Prescaler, pt, ped_pend and synchronizer flops cleared; last=PED.
- First `slowclk` occurs CLK_DIV clks after clr_n deasserts.
- All outputs are registered and change on the clk edge where the tick is high. Lamp outputs have no combinational path from inputs.
- Sensor latency: an `x` edge becomes visible in `x_s` 2 clks later. It acts on the first tick after that.
- A phase lasting T ticks holds its outputs for exactly T×CLK_DIV clks.
- Reset asserted mid-phase: outputs go to reset values immediately, with no yellow/all-red sequence. Pending requests are lost.
- `x` dropping during CY or AR2 has no effect. `x` high during WALK is served on the next HG exit, after T_HWY_MIN.

## Structure
- Package `tlc_pkg` holds:
  - lamp codes GREEN=2'b00, YELLOW=2'b01, RED=2'b10;
  - the phase enum (HG..WALK, 3 bits);
  - the target enum (CTRY, PED).
- Sub-module `tlc_prescaler`: parameter CLK_DIV; ports clk, clr_n, tick.
- The rest is one FSM with the timer, synchronizer and arbitration registers.

## Test plan
All scenarios use default parameters.
- Reset and tick: hold clr_n low for 3 clks → hwy=00, cntry=10, slowclk=0. After release, slowclk pulses on clks 4, 8, 12.
- Max country green: hold x=1 from reset → HG 3 ticks, HY 2, AR1 1, CG 5 (capped by T_CNTRY_MAX), CY 2, AR2 1, then back in HG with hwy=00.
- Early country exit: x=1 until CG is entered, then x=0 → CG lasts 1 tick, followed by CY 2 ticks.
- Pedestrian: one-clk ped_req pulse with x=0 → after 3 HG ticks, HY, AR1, then WALK with ped_walk=1 for 8 clks, then AR2 and HG. ped_pend reads 0 in WALK.
- Contention: x=1 and ped_req from reset → CG first. The next HG exit goes to WALK even though x=1, then the one after goes to CG.
- Mid-phase reset: pull clr_n low in CG at pt=2 → within the same clk, hwy=00, cntry=10, phase=0. After release, timing restarts from a full T_HWY_MIN.
